// File: rtl/stage_seq_if.sv
// Stage sequencer bus: per-stage wait and halt requests in, stage enables,
// retire/halt status and performance counters out.
interface stage_seq_if #(
  parameter int N_STAGES = 5
);
  localparam int SW = $clog2(N_STAGES);

  logic [N_STAGES-1:0] stage_wait;
  logic                halt;
  logic [N_STAGES-1:0] en;
  logic [SW-1:0]       stage;
  logic                retire;
  logic                halted;
  logic [31:0]         retire_cnt;
  logic [31:0]         wait_cnt;

  modport master (
    input  stage_wait, halt,
    output en, stage, retire, halted, retire_cnt, wait_cnt
  );

  modport slave (
    output stage_wait, halt,
    input  en, stage, retire, halted, retire_cnt, wait_cnt
  );
endinterface

// File: rtl/stage_seq.sv
// Multi-cycle stage sequencer: one stage enable at a time, per-stage minimum dwell,
// wait extension and halt at instruction boundaries. Perf counters under STAGE_SEQ_PERF_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | out of reset; starts RUN(0) or parks in HALTED next edge
// ST_RUN     | stage stage_q active, count = cycles already spent in it
// ST_HALTED  | parked between instructions until halt drops
module stage_seq #(
  parameter int                        N_STAGES = 5,
  parameter int                        CNT_W    = 4,
  parameter logic [N_STAGES*CNT_W-1:0] CYC      = {N_STAGES{4'd1}}
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  stage_seq_if.master  bus
);
  localparam int SW = $clog2(N_STAGES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [SW-1:0]     stage_q;
  logic [CNT_W-1:0]  count;

  logic              stage_ok;
  logic              last_stage;
  logic [CNT_W-1:0]  cyc_cur;
  logic [CNT_W-1:0]  min_cyc;
  logic              wait_cur;
  logic [CNT_W:0]    count_inc;
  logic              reached;
  logic              done;
  logic              in_run;
  logic [N_STAGES-1:0] en_dec;

  // Per-stage lookups via a loop so out-of-range indices never read past the vectors.
  always_comb begin
    cyc_cur  = '0;
    wait_cur = 1'b0;
    en_dec   = '0;
    stage_ok = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (32'(stage_q) == i) begin
        cyc_cur   = CYC[i*CNT_W +: CNT_W];
        wait_cur  = bus.stage_wait[i];
        en_dec[i] = 1'b1;
        stage_ok  = 1'b1;
      end
    end
  end

  assign min_cyc    = (cyc_cur == '0) ? CNT_W'(1) : cyc_cur;
  assign count_inc  = {1'b0, count} + (CNT_W+1)'(1);
  assign reached    = count_inc >= {1'b0, min_cyc};
  assign done       = reached && !wait_cur;
  assign last_stage = (32'(stage_q) == N_STAGES - 1);
  assign in_run     = (state == ST_RUN) && stage_ok;

  assign bus.en     = in_run ? en_dec : '0;
  assign bus.stage  = in_run ? stage_q : '0;
  assign bus.retire = in_run && last_stage && done;
  assign bus.halted = (state == ST_HALTED);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      stage_q <= '0;
      count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= bus.halt ? ST_HALTED : ST_RUN;
          stage_q <= '0;
          count   <= '0;
        end
        ST_RUN: begin
          if (!stage_ok) begin
            stage_q <= '0;
            count   <= '0;
          end else if (done) begin
            count <= '0;
            if (last_stage) begin
              stage_q <= '0;
              if (bus.halt) state <= ST_HALTED;
            end else begin
              stage_q <= stage_q + 1'b1;
            end
          end else if (count != '1) begin
            count <= count + 1'b1;
          end
        end
        ST_HALTED: begin
          if (!bus.halt) begin
            state   <= ST_RUN;
            stage_q <= '0;
            count   <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          stage_q <= '0;
          count   <= '0;
        end
      endcase
    end
  end

`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] retire_cnt_q;
  logic [31:0] wait_cnt_q;

  // Wait cycles count only once the minimum dwell has elapsed.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      retire_cnt_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      if (bus.retire) retire_cnt_q <= retire_cnt_q + 32'd1;
      if (in_run && reached && wait_cur) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign bus.retire_cnt = retire_cnt_q;
  assign bus.wait_cnt   = wait_cnt_q;
`else
  assign bus.retire_cnt = '0;
  assign bus.wait_cnt   = '0;
`endif
endmodule
